// File: rtl/load_store_unit_pkg.sv
// Shared constants and helpers for the RV32I load/store unit.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsuState_t;

    // Unsigned encodings only exist for loads.
    function automatic logic f3Legal(input logic [2:0] f3,
                                     input logic isStore);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = !isStore;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3Aligned(input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        case (f3[1:0])
            2'b01:   ok = !off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] strobeFor(input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [3:0] s;
        s = STRB_WORD;
        case (f3[1:0])
            2'b00:   s = STRB_BYTE << off;
            2'b01:   s = STRB_HALF << off;
            default: s = STRB_WORD;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] laneData(input logic [2:0] f3,
                                             input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Lane select and sign/zero extension of a returned bus word.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    assign byteLane = rdata[{offset, 3'b000} +: 8];
    assign halfLane = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        value = rdata;
        case (funct3[1:0])
            2'b00: value = funct3[2] ? {24'b0, byteLane}
                                     : {{24{byteLane[7]}}, byteLane};
            2'b01: value = funct3[2] ? {16'b0, halfLane}
                                     : {{16{halfLane[15]}}, halfLane};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one word-aligned bus transaction per request.
// Define LSU_TIMEOUT_EN to abort a bus wait after TIMEOUT_CYCLES.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oLoadData,
    output logic        oMisaligned,
    output logic        oBusError,
    output logic        oBusReq,
    output logic        oBusWe,
    output logic [31:0] oBusAddr,
    output logic [31:0] oBusWData,
    output logic [3:0]  oBusWStrb,
    input  logic        iBusAck,
    input  logic [31:0] iBusRData
);

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    lsuState_t   state;
    logic [1:0]  offQ;
    logic [2:0]  f3Q;
    logic [31:0] loadExt;
    logic        accept;
    logic        good;
    logic        timeout;

    assign accept = (state == LSU_IDLE) && iStart
                    && (iMemRead ^ iMemWrite);
    assign good   = f3Legal(iFunct3, iMemWrite)
                    && f3Aligned(iFunct3, iAddress[1:0]);
    assign oBusy  = (state != LSU_IDLE);

    load_extend uExtend (
        .rdata  (iBusRData),
        .offset (offQ),
        .funct3 (f3Q),
        .value  (loadExt)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] waitCnt;

    // Counts completed REQ cycles; clears whenever we are not waiting.
    always_ff @(posedge iCLK) begin
        if (iRST || state != LSU_REQ) begin
            waitCnt <= '0;
        end else if (!timeout) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign timeout = (state == LSU_REQ) && (waitCnt == LIMIT);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= LSU_IDLE;
            offQ        <= '0;
            f3Q         <= '0;
            oDone       <= 1'b0;
            oMisaligned <= 1'b0;
            oBusError   <= 1'b0;
            oLoadData   <= '0;
            oBusReq     <= 1'b0;
            oBusWe      <= 1'b0;
            oBusAddr    <= '0;
            oBusWData   <= '0;
            oBusWStrb   <= '0;
        end else begin
            unique case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        offQ <= iAddress[1:0];
                        f3Q  <= iFunct3;
                        if (good) begin
                            state     <= LSU_REQ;
                            oBusReq   <= 1'b1;
                            oBusWe    <= iMemWrite;
                            oBusAddr  <= {iAddress[31:2], 2'b00};
                            oBusWData <= laneData(iFunct3, iWriteData);
                            oBusWStrb <= strobeFor(iFunct3, iAddress[1:0]);
                        end else begin
                            state       <= LSU_DONE;
                            oDone       <= 1'b1;
                            oMisaligned <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    // Ack beats a timeout reached in the same cycle.
                    if (iBusAck) begin
                        state   <= LSU_DONE;
                        oBusReq <= 1'b0;
                        oDone   <= 1'b1;
                        if (!oBusWe) begin
                            oLoadData <= loadExt;
                        end
                    end else if (timeout) begin
                        state     <= LSU_DONE;
                        oBusReq   <= 1'b0;
                        oDone     <= 1'b1;
                        oBusError <= 1'b1;
                    end
                end
                LSU_DONE: begin
                    state       <= LSU_IDLE;
                    oDone       <= 1'b0;
                    oMisaligned <= 1'b0;
                    oBusError   <= 1'b0;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iStart = 1'b0;
    logic        iMemRead = 1'b0;
    logic        iMemWrite = 1'b0;
    logic [2:0]  iFunct3 = '0;
    logic [31:0] iAddress = '0;
    logic [31:0] iWriteData = '0;
    logic        iBusAck = 1'b0;
    logic [31:0] iBusRData = '0;
    logic        oBusy, oDone, oMisaligned, oBusError;
    logic        oBusReq, oBusWe;
    logic [31:0] oLoadData, oBusAddr, oBusWData;
    logic [3:0]  oBusWStrb;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite),
        .iFunct3(iFunct3), .iAddress(iAddress),
        .iWriteData(iWriteData), .oBusy(oBusy), .oDone(oDone),
        .oLoadData(oLoadData), .oMisaligned(oMisaligned),
        .oBusError(oBusError), .oBusReq(oBusReq), .oBusWe(oBusWe),
        .oBusAddr(oBusAddr), .oBusWData(oBusWData),
        .oBusWStrb(oBusWStrb), .iBusAck(iBusAck),
        .iBusRData(iBusRData)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int failures = 0;
    bit chkEn = 0;

    // Expected outputs for the current cycle, set by the driver.
    logic        expBusy = 0, expDone = 0, expMis = 0, expErr = 0;
    logic        expReq = 0, expWe = 0;
    logic [31:0] expLoad = 0, expAddr = 0, expWData = 0;
    logic [3:0]  expStrb = 0;

    // Observations used by the literal checks.
    int          obsDone;
    bit          obsReq;
    logic        obsWe;
    logic [31:0] obsAddr, obsWData;
    logic [3:0]  obsStrb;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (chkEn) begin
            chk("busy", 32'(oBusy), 32'(expBusy));
            chk("done", 32'(oDone), 32'(expDone));
            chk("misaligned", 32'(oMisaligned), 32'(expMis));
            chk("busError", 32'(oBusError), 32'(expErr));
            chk("busReq", 32'(oBusReq), 32'(expReq));
            chk("loadData", oLoadData, expLoad);
            if (expReq) begin
                chk("busWe", 32'(oBusWe), 32'(expWe));
                chk("busAddr", oBusAddr, expAddr);
                chk("busWData", oBusWData, expWData);
                chk("busWStrb", 32'(oBusWStrb), 32'(expStrb));
            end
        end
    end

    function automatic bit legalModel(input logic [2:0] f3, input bit wr);
        return (f3 <= 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
    endfunction

    function automatic logic [3:0] strbModel(input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [3:0] s;
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < 4; i++)
            s[i] = (i >= int'(off)) && (i < int'(off) + size);
        return s;
    endfunction

    function automatic logic [31:0] wdModel(input logic [2:0] f3,
                                            input logic [31:0] wd);
        logic [31:0] d;
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < 4; i++)
            d[8*i +: 8] = wd[8*(i % size) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] extModel(input logic [31:0] rd,
                                             input logic [1:0] off,
                                             input logic [2:0] f3);
        int n;
        logic [31:0] v, mask;
        n = 8 << f3[1:0];
        v = rd >> (8 * int'(off));
        if (n == 32) return v;
        mask = (32'h1 << n) - 32'h1;
        v = v & mask;
        if (!f3[2] && v[n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick(input int cyc);
        @(negedge iCLK);
        if (oDone && obsDone < 0) obsDone = cyc;
        if (oBusReq) begin
            obsReq = 1;
            obsWe = oBusWe;
            obsAddr = oBusAddr;
            obsWData = oBusWData;
            obsStrb = oBusWStrb;
        end
        @(posedge iCLK);
        #1;
    endtask

    task automatic setIdle();
        expBusy = 0; expDone = 0; expMis = 0; expErr = 0; expReq = 0;
    endtask

    task automatic setBus(input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        expWe = wr;
        expAddr = addr & 32'hFFFF_FFFC;
        expStrb = strbModel(f3, addr[1:0]);
        expWData = wdModel(f3, wd);
    endtask

    task automatic present(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        iStart = 1; iMemRead = rd; iMemWrite = wr;
        iFunct3 = f3; iAddress = addr; iWriteData = wd;
        iBusAck = 1'($urandom); iBusRData = $urandom;
    endtask

    // Called in an IDLE cycle (posedge + 1); returns in an IDLE cycle.
    task automatic run(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int waits, input logic [31:0] rdata);
        int size, n;
        bit tmo;
        obsDone = -1; obsReq = 0;
        present(rd, wr, f3, addr, wd);
        tick(0);
        iStart = 0;
        iBusAck = 1'($urandom);
        if (!(rd ^ wr)) return;
        size = 1 << f3[1:0];
        if (!legalModel(f3, wr) || (addr % size) != 0) begin
            expBusy = 1; expDone = 1; expMis = 1;
            tick(1);
            setIdle();
            iBusAck = 0;
            return;
        end
        n = waits + 1;
        tmo = 0;
`ifdef LSU_TIMEOUT_EN
        if (waits >= TO) begin
            n = TO;
            tmo = 1;
        end
`endif
        setBus(wr, f3, addr, wd);
        expBusy = 1; expReq = 1;
        for (int k = 0; k < n; k++) begin
            iStart = 1'($urandom);
            iMemRead = 1'($urandom);
            iMemWrite = 1'($urandom);
            iAddress = $urandom;
            iBusAck = (k == waits);
            iBusRData = (k == waits) ? rdata : $urandom;
            tick(k + 1);
        end
        iBusAck = 1'($urandom);
        iBusRData = $urandom;
        expReq = 0; expDone = 1; expErr = tmo;
        if (!wr && !tmo) expLoad = extModel(rdata, addr[1:0], f3);
        tick(n + 1);
        iStart = 0; iBusAck = 0;
        setIdle();
    endtask

    initial begin
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        chkEn = 1;
        tick(0);
        iRST = 0;
        tick(0);

        run(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        chk("lw_latency", 32'(obsDone), 32'd2);
        chk("lw_addr", obsAddr, 32'h100);
        chk("lw_strb", 32'(obsStrb), 32'hF);
        chk("lw_data", oLoadData, 32'hDEADBEEF);

        run(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80AABBCC);
        chk("lb_strb", 32'(obsStrb), 32'h8);
        chk("lb_data", oLoadData, 32'hFFFFFF80);
        run(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80AABBCC);
        chk("lbu_data", oLoadData, 32'h00000080);

        run(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'h0);
        chk("sh_we", 32'(obsWe), 32'd1);
        chk("sh_strb", 32'(obsStrb), 32'hC);
        chk("sh_wdata", obsWData, 32'hABCDABCD);
        chk("sh_latency", 32'(obsDone), 32'd5);
        chk("sh_load_kept", oLoadData, 32'h00000080);

        run(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
        chk("mis_latency", 32'(obsDone), 32'd1);
        chk("mis_noreq", 32'(obsReq), 32'd0);

        run(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0);
        tick(1);
        run(0, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0);
        tick(1);

        // Reset while waiting for the bus.
        obsDone = -1;
        present(1, 0, 3'b010, 32'h300, 32'h0);
        iBusAck = 0;
        tick(0);
        iStart = 0;
        setBus(0, 3'b010, 32'h300, 32'h0);
        expBusy = 1; expReq = 1;
        tick(1);
        iRST = 1;
        tick(2);
        iRST = 0;
        setIdle();
        expLoad = 0;
        tick(3);
        chk("rst_nodone", 32'(obsDone), 32'hFFFF_FFFF);
        run(1, 0, 3'b101, 32'h302, 32'h0, 0, 32'h9876_0000);
        chk("post_rst_lhu", oLoadData, 32'h0000_9876);

        run(1, 0, 3'b010, 32'h400, 32'h0, 15, 32'h1111_2222);
        chk("ack_at_limit", 32'(obsDone), 32'd17);
`ifdef LSU_TIMEOUT_EN
        run(1, 0, 3'b010, 32'h404, 32'h0, 20, 32'h3333_4444);
        chk("timeout_latency", 32'(obsDone), 32'd17);
        chk("timeout_load_kept", oLoadData, 32'h1111_2222);
`else
        run(1, 0, 3'b010, 32'h404, 32'h0, 20, 32'h3333_4444);
        chk("long_wait", 32'(obsDone), 32'd22);
`endif

        for (int t = 0; t < 300; t++) begin
            bit rd, wr;
            int sel;
            sel = int'($urandom_range(0, 9));
            rd = (sel < 5) || (sel == 9);
            wr = (sel >= 5);
            run(rd, wr, 3'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 4)), $urandom);
        end

        chkEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage that consumes the ALU result as the effective address for loads and stores in the RV32I datapath. It turns a load or store request into one word-aligned bus transaction with byte strobes. For loads it lane-selects and sign- or zero-extends the returned word. It also flags misaligned or illegal accesses without touching the bus.

Parameters:
TIMEOUT_CYCLES, 16, bus-wait limit before an error is reported (used only with LSU_TIMEOUT_EN)

Ports:
iCLK  in  1  system clock; everything is sampled on the rising edge
iRST  in  1  reset, synchronous, active-high
iStart  in  1  request pulse; accepted only in IDLE
iMemRead  in  1  load request
iMemWrite  in  1  store request
iFunct3  in  3  access size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
iAddress  in  32  effective address, taken from the ALU result
iWriteData  in  32  store data (rs2)
oBusy  out  1  high whenever state != IDLE
oDone  out  1  one-cycle completion pulse
oLoadData  out  32  extended load result; holds its value until the next completed load
oMisaligned  out  1  valid with oDone: address misaligned or funct3 illegal
oBusError  out  1  valid with oDone: bus timeout
oBusReq  out  1  bus request, held until acknowledged
oBusWe  out  1  bus write enable
oBusAddr  out  32  word-aligned address {addr[31:2],2'b00}
oBusWData  out  32  store data replicated across lanes
oBusWStrb  out  4  byte-lane strobes
iBusAck  in  1  bus acknowledge; read data is valid in the same cycle
iBusRData  in  32  bus read word

Behaviour:
- Reset: state=IDLE; all outputs 0, including oLoadData. Reset mid-transaction drops oBusReq at the same edge and produces no oDone.
- Accept condition: IDLE && iStart && exactly one of iMemRead/iMemWrite. On accept, register the address, funct3, write data and direction.
- Ignored requests: iStart with both or neither of iMemRead/iMemWrite; iStart while busy.
- Alignment check, done at accept:
  - halfword requires addr[0]=0; word requires addr[1:0]=00.
  - funct3 011/110/111 is illegal; LBU/LHU encodings on a store (100/101) are illegal.
  - On a failed check: state goes to DONE with no bus activity. oDone=1 and oMisaligned=1 one cycle after accept.
- States:
  - IDLE -> REQ on a good accept.
  - IDLE -> DONE on a failed check.
  - REQ -> DONE when iBusAck=1.
  - DONE -> IDLE unconditionally.
- REQ outputs: oBusReq=1; oBusAddr, oBusWe, oBusWData and oBusWStrb stay stable until ack.
- Strobes, with off=addr[1:0]:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
  - loads drive the same strobes as stores.
- oBusWData:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Load extract:
  - byte lane = rdata[8*off +: 8]; half lane = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Captured into oLoadData at the ack edge, so it is valid while oDone=1.
- Stores and errors leave oLoadData unchanged.
- Latency: with a zero-wait bus (ack in first REQ cycle), oDone is asserted 2 cycles after the accept edge. Each wait cycle adds 1.
- oDone, oMisaligned and oBusError are high only in DONE. A new iStart may be accepted in the cycle after DONE, i.e. in IDLE.
- iBusAck outside REQ is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A counter runs in REQ from 0.
  - If TIMEOUT_CYCLES consecutive REQ cycles pass with no ack, the unit drops oBusReq, enters DONE with oBusError=1, and leaves oLoadData unchanged.
  - Ack in the same cycle the limit is reached wins: normal completion.
- Undefined: REQ waits indefinitely and oBusError is tied 0. The port exists in both builds.

Decomposition:
- Shared params include: funct3 constants (F3_LB..F3_LHU), state encodings (LSU_IDLE, LSU_REQ, LSU_DONE), strobe constants.
- Sub-module load_extend: combinational lane select and sign/zero extension. Inputs: rdata, offset, funct3. Output: 32-bit value. It is reusable by a future cache.

Test Plan:
- LW, addr=0x100, zero-wait bus, rdata=0xDEADBEEF -> oBusAddr=0x100, strb=1111, oDone 2 cycles after start, oLoadData=0xDEADBEEF.
- LB at 0x103, rdata=0x80AABBCC -> strb=1000, oLoadData=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr=0x202, wd=0x1234ABCD, ack after 3 wait cycles:
  - oBusWe=1, strb=1100, wdata=0xABCDABCD, all held stable through the waits.
  - oDone at cycle 5; oLoadData unchanged.
- LW addr=0x101 -> no oBusReq; oDone=1 and oMisaligned=1 at cycle 1. iStart with both iMemRead and iMemWrite -> ignored, oBusy stays 0.
- Reset asserted during REQ -> next cycle: oBusReq=0, oBusy=0, no oDone. A later iStart is accepted normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> oBusReq drops and oDone=1, oBusError=1 after 16 REQ cycles. A rerun with ack in REQ cycle 16 -> normal completion, oBusError=0.
